// File: rtl/ext_accel_pwr_intr_ctrl.sv
// Per-channel power-gate sequencer and edge-latched interrupt controller
// for external accelerator domains.
module ext_accel_pwr_intr_ctrl #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned NEXT_INT    = 64,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned RST_DELAY   = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NCH-1:0]      accel_intr_i,
  input  logic [NCH-1:0]      intr_mask_i,
  input  logic [NCH-1:0]      intr_clear_i,
  output logic [NCH-1:0]      intr_pending_o,
  output logic [NEXT_INT-1:0] intr_vector_ext_o,
  input  logic [NCH-1:0]      pwr_req_i,
  output logic [NCH-1:0]      pwr_switch_o,
  input  logic [NCH-1:0]      pwr_switch_ack_i,
  output logic [NCH-1:0]      pwr_iso_o,
  output logic [NCH-1:0]      accel_rst_no,
  output logic [NCH-1:0]      accel_clk_en_o,
  output logic [NCH-1:0]      pwr_err_o,
  output logic [3*NCH-1:0]    pwr_state_o
);

  localparam logic [2:0] S_OFF     = 3'd0;
  localparam logic [2:0] S_PWR_UP  = 3'd1;
  localparam logic [2:0] S_ISO_REL = 3'd2;
  localparam logic [2:0] S_ON      = 3'd3;
  localparam logic [2:0] S_CLK_OFF = 3'd4;
  localparam logic [2:0] S_ISO_ON  = 3'd5;
  localparam logic [2:0] S_PWR_DN  = 3'd6;

  localparam int unsigned CMAX =
    (ACK_TIMEOUT > RST_DELAY) ? ACK_TIMEOUT : RST_DELAY;
  localparam int unsigned CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_DELAY - 1);

  logic [NCH-1:0][2:0]    state_q, state_d;
  logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]         err_q, err_d;
  logic [NCH-1:0]         pend_q, pend_d;
  logic [NCH-1:0]         irq_s_q, irq_p_q;
  logic [NCH-1:0]         irq_rise;

  assign irq_rise = irq_s_q & ~irq_p_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pend_d  = pend_q;
    for (int i = 0; i < NCH; i++) begin
      case (state_q[i])
        S_OFF: begin
          if (!pwr_req_i[i]) begin
            err_d[i] = 1'b0;
          end else if (!err_q[i]) begin
            state_d[i] = S_PWR_UP;
            cnt_d[i]   = '0;
          end
        end
        S_PWR_UP: begin
          if (pwr_switch_ack_i[i]) begin
            state_d[i] = S_ISO_REL;
            cnt_d[i]   = '0;
          end else if (!pwr_req_i[i]) begin
            state_d[i] = S_PWR_DN;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == ACK_LAST) begin
            state_d[i] = S_OFF;
            err_d[i]   = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        S_ISO_REL: begin
          if (!pwr_req_i[i]) begin
            state_d[i] = S_ISO_ON;
          end else if (cnt_q[i] == RST_LAST) begin
            state_d[i] = S_ON;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        S_ON: begin
          if (!pwr_req_i[i]) state_d[i] = S_CLK_OFF;
        end
        S_CLK_OFF: state_d[i] = S_ISO_ON;
        S_ISO_ON: begin
          state_d[i] = S_PWR_DN;
          cnt_d[i]   = '0;
        end
        S_PWR_DN: begin
          if (!pwr_switch_ack_i[i]) begin
            state_d[i] = S_OFF;
          end else if (cnt_q[i] == ACK_LAST) begin
            state_d[i] = S_OFF;
            err_d[i]   = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: state_d[i] = S_OFF;
      endcase
      // Set beats clear; a channel dropping to OFF loses its pending bit.
      if (state_d[i] == S_OFF) begin
        pend_d[i] = 1'b0;
      end else if (irq_rise[i] && state_q[i] == S_ON) begin
        pend_d[i] = 1'b1;
      end else if (intr_clear_i[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      pend_q  <= '0;
      irq_s_q <= '0;
      irq_p_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      irq_s_q <= accel_intr_i;
      irq_p_q <= irq_s_q;
    end
  end

  always_comb begin
    pwr_switch_o   = '0;
    pwr_iso_o      = '1;
    accel_rst_no   = '0;
    accel_clk_en_o = '0;
    for (int i = 0; i < NCH; i++) begin
      case (state_q[i])
        S_PWR_UP,
        S_ISO_ON: begin
          pwr_switch_o[i] = 1'b1;
        end
        S_ISO_REL: begin
          pwr_switch_o[i] = 1'b1;
          pwr_iso_o[i]    = 1'b0;
        end
        S_ON: begin
          pwr_switch_o[i]   = 1'b1;
          pwr_iso_o[i]      = 1'b0;
          accel_rst_no[i]   = 1'b1;
          accel_clk_en_o[i] = 1'b1;
        end
        S_CLK_OFF: begin
          pwr_switch_o[i] = 1'b1;
          pwr_iso_o[i]    = 1'b0;
          accel_rst_no[i] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    intr_vector_ext_o          = '0;
    intr_vector_ext_o[NCH-1:0] = pend_q & intr_mask_i;
  end

  assign intr_pending_o = pend_q;
  assign pwr_err_o      = err_q;
  assign pwr_state_o    = state_q;

endmodule

// File: tb/tb_ext_accel_pwr_intr_ctrl.sv
// Directed bench for ext_accel_pwr_intr_ctrl: sequencing, timeout,
// abort, interrupt path and async reset.
module tb_ext_accel_pwr_intr_ctrl;

  localparam int NCH = 4;
  localparam int NEXT_INT = 64;

  logic                clk = 1'b0;
  logic                rst;
  logic [NCH-1:0]      accel_intr;
  logic [NCH-1:0]      intr_mask;
  logic [NCH-1:0]      intr_clear;
  logic [NCH-1:0]      intr_pending;
  logic [NEXT_INT-1:0] intr_vec;
  logic [NCH-1:0]      pwr_req;
  logic [NCH-1:0]      pwr_switch;
  logic [NCH-1:0]      pwr_ack;
  logic [NCH-1:0]      pwr_iso;
  logic [NCH-1:0]      accel_rst_n;
  logic [NCH-1:0]      accel_clk_en;
  logic [NCH-1:0]      pwr_err;
  logic [3*NCH-1:0]    pwr_state;

  int n_run = 0;
  int n_fail = 0;

  ext_accel_pwr_intr_ctrl #(
    .NCH(NCH), .NEXT_INT(NEXT_INT),
    .ACK_TIMEOUT(8), .RST_DELAY(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .accel_intr_i(accel_intr),
    .intr_mask_i(intr_mask),
    .intr_clear_i(intr_clear),
    .intr_pending_o(intr_pending),
    .intr_vector_ext_o(intr_vec),
    .pwr_req_i(pwr_req),
    .pwr_switch_o(pwr_switch),
    .pwr_switch_ack_i(pwr_ack),
    .pwr_iso_o(pwr_iso),
    .accel_rst_no(accel_rst_n),
    .accel_clk_en_o(accel_clk_en),
    .pwr_err_o(pwr_err),
    .pwr_state_o(pwr_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {switch, iso, rst_no, clk_en, state} for one channel
  function automatic logic [6:0] ch(input int i);
    return {pwr_switch[i], pwr_iso[i], accel_rst_n[i],
            accel_clk_en[i], pwr_state[3*i +: 3]};
  endfunction

  function automatic logic [6:0] pat(input logic [2:0] s);
    case (s)
      3'd1:    return {4'b1100, s};
      3'd2:    return {4'b1000, s};
      3'd3:    return {4'b1011, s};
      3'd4:    return {4'b1010, s};
      3'd5:    return {4'b1100, s};
      3'd6:    return {4'b0100, s};
      default: return {4'b0100, s};
    endcase
  endfunction

  initial begin
    logic [2:0] es;
    rst = 1'b1;
    accel_intr = '0;
    intr_mask = '0;
    intr_clear = '0;
    pwr_req = '0;
    pwr_ack = '0;
    #12;
    chk("rst_sw", 64'(pwr_switch), 64'h0);
    chk("rst_iso", 64'(pwr_iso), 64'hF);
    chk("rst_rstn", 64'(accel_rst_n), 64'h0);
    chk("rst_clken", 64'(accel_clk_en), 64'h0);
    chk("rst_state", 64'(pwr_state), 64'h0);
    chk("rst_vec", intr_vec, 64'h0);
    chk("rst_pend_err", 64'({intr_pending, pwr_err}), 64'h0);
    tick();
    rst = 1'b0;

    // Channel 0 power-up; ack rises at cycle 5
    pwr_req[0] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      es = (c < 6) ? 3'd1 : ((c < 10) ? 3'd2 : 3'd3);
      chk("up0", 64'(ch(0)), 64'(pat(es)));
      if (c == 5) pwr_ack[0] = 1'b1;
    end

    // Channel 1 ack timeout
    pwr_req[1] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c <= 8) begin
        chk("to1_up", 64'(ch(1)), 64'(pat(3'd1)));
      end else begin
        chk("to1_off", 64'(ch(1)), 64'(pat(3'd0)));
        chk("to1_err", 64'(pwr_err[1]), 64'h1);
      end
    end
    pwr_req[1] = 1'b0;
    tick();
    chk("to1_errclr", 64'(pwr_err[1]), 64'h0);
    chk("to1_off2", 64'(ch(1)), 64'(pat(3'd0)));
    pwr_req[1] = 1'b1;
    tick();
    chk("to1_retry", 64'(ch(1)), 64'(pat(3'd1)));
    pwr_req[1] = 1'b0;
    tick();
    chk("to1_dn", 64'(ch(1)), 64'(pat(3'd6)));
    tick();
    chk("to1_off3", 64'(ch(1)), 64'(pat(3'd0)));

    // Edges on a channel that is not ON are ignored
    intr_mask[1] = 1'b1;
    accel_intr[1] = 1'b1;
    tick(); tick(); tick();
    chk("irq_off_ign", 64'(intr_pending[1]), 64'h0);

    // Interrupt path on channel 0
    intr_mask[0] = 1'b1;
    accel_intr[0] = 1'b1;
    tick();
    chk("irq_lat1", intr_vec, 64'h0);
    tick();
    chk("irq_vec", intr_vec, 64'h1);
    accel_intr[0] = 1'b0;
    tick();
    accel_intr[0] = 1'b1;
    tick();
    intr_clear[0] = 1'b1;
    tick();
    intr_clear[0] = 1'b0;
    chk("irq_setwins", 64'(intr_pending[0]), 64'h1);
    intr_clear[0] = 1'b1;
    tick();
    intr_clear[0] = 1'b0;
    chk("irq_clr_pend", 64'(intr_pending[0]), 64'h0);
    chk("irq_clr_vec", intr_vec, 64'h0);
    accel_intr[0] = 1'b0;
    tick();
    accel_intr[0] = 1'b1;
    tick();
    tick();
    chk("irq_reset", 64'(intr_pending[0]), 64'h1);
    intr_mask[0] = 1'b0;
    #1;
    chk("irq_mask_vec", intr_vec, 64'h0);
    chk("irq_mask_pend", 64'(intr_pending[0]), 64'h1);
    intr_mask[0] = 1'b1;

    // Channel 2 on, pending set, then power-down
    pwr_req[2] = 1'b1;
    pwr_ack[2] = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    chk("dn2_on", 64'(ch(2)), 64'(pat(3'd3)));
    intr_mask[2] = 1'b1;
    accel_intr[2] = 1'b1;
    tick(); tick();
    chk("dn2_pend", 64'(intr_pending[2]), 64'h1);
    pwr_req[2] = 1'b0;
    tick();
    chk("dn2_clkoff", 64'(ch(2)), 64'(pat(3'd4)));
    tick();
    chk("dn2_iso", 64'(ch(2)), 64'(pat(3'd5)));
    tick();
    chk("dn2_pwrdn", 64'(ch(2)), 64'(pat(3'd6)));
    chk("dn2_pend_hold", 64'(intr_pending[2]), 64'h1);
    pwr_ack[2] = 1'b0;
    tick();
    chk("dn2_off", 64'(ch(2)), 64'(pat(3'd0)));
    chk("dn2_pend_clr", 64'(intr_pending[2]), 64'h0);

    // Channel 3 abort during ISO_REL
    pwr_req[3] = 1'b1;
    pwr_ack[3] = 1'b1;
    tick();
    chk("ab3_up", 64'(ch(3)), 64'(pat(3'd1)));
    tick();
    chk("ab3_rel1", 64'(ch(3)), 64'(pat(3'd2)));
    tick();
    chk("ab3_rel2", 64'(ch(3)), 64'(pat(3'd2)));
    pwr_req[3] = 1'b0;
    tick();
    chk("ab3_isoon", 64'(ch(3)), 64'(pat(3'd5)));
    tick();
    chk("ab3_pwrdn", 64'(ch(3)), 64'(pat(3'd6)));
    pwr_ack[3] = 1'b0;
    tick();
    chk("ab3_off", 64'(ch(3)), 64'(pat(3'd0)));

    // All channels ON with pending, then async reset
    accel_intr = '0;
    pwr_req = 4'hF;
    pwr_ack = 4'hF;
    for (int c = 0; c < 8; c++) tick();
    chk("all_on", 64'(pwr_state), 64'h6DB);
    intr_mask = 4'hF;
    accel_intr = 4'hF;
    tick(); tick();
    chk("all_vec", intr_vec, 64'hF);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_sw", 64'(pwr_switch), 64'h0);
    chk("ar_iso", 64'(pwr_iso), 64'hF);
    chk("ar_rstn", 64'(accel_rst_n), 64'h0);
    chk("ar_clken", 64'(accel_clk_en), 64'h0);
    chk("ar_pend", 64'(intr_pending), 64'h0);
    chk("ar_err", 64'(pwr_err), 64'h0);
    chk("ar_vec", intr_vec, 64'h0);
    chk("ar_state", 64'(pwr_state), 64'h0);
    tick();
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/ext_accel_pwr_intr_ctrl.md
Name: ext_accel_pwr_intr_ctrl

Overview:
- Parametrised controller for NCH external accelerator domains on X-HEEP.
- Per channel it provides:
  - power-gate sequencing: switch, ack, isolation, reset and clock enable, with an ack timeout;
  - edge-latched, maskable, clearable interrupt pending bits.
- The pending bits are mapped onto lines [NCH-1:0] of the external interrupt vector.
- Replaces per-accelerator hardwiring, where a single interrupt drives line 0 and the clock enable is tied on.

Parameters:
- NCH, 4, number of accelerator channels (1..NEXT_INT).
- NEXT_INT, 64, width of the external interrupt vector.
- ACK_TIMEOUT, 255, maximum cycles to wait for a switch ack edge before flagging an error (>=1).
- RST_DELAY, 4, cycles between isolation release and reset deassert (>=1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- accel_intr_i  in  NCH  interrupt request from each accelerator (level; the rising edge is captured).
- intr_mask_i  in  NCH  1 = enable that channel's line.
- intr_clear_i  in  NCH  1-cycle pulse, clears the pending bit.
- intr_pending_o  out  NCH  pending bits, unmasked.
- intr_vector_ext_o  out  NEXT_INT  to intr_vector_ext_i of x_heep_system.
- pwr_req_i  in  NCH  level; 1 = channel requested on.
- pwr_switch_o  out  NCH  1 = power switch closed (domain powered).
- pwr_switch_ack_i  in  NCH  1 = domain power good.
- pwr_iso_o  out  NCH  1 = outputs isolated.
- accel_rst_no  out  NCH  active-low logic reset to the accelerator.
- accel_clk_en_o  out  NCH  clock-gate enable.
- pwr_err_o  out  NCH  sticky ack-timeout flag.
- pwr_state_o  out  3*NCH  FSM state per channel, channel i at bits [3i+2:3i].

Behaviour:
Reset (rst_i=1, async):
- state OFF; pending 0; err 0; counters 0.
- switch 0, iso 1, rst_no 0, clk_en 0.
- intr_vector_ext_o all 0.

Outputs:
- All power outputs are decoded from the registered state (Moore).
- A transition taken at edge t is visible after edge t.

Per-channel FSM (3-bit encoding). Each state lists switch/iso/rst_no/clk_en, then its exits:
- OFF=0: 0/1/0/0.
  - req=1 & err=0 -> PWR_UP; counter cleared.
  - req=0 -> err cleared.
- PWR_UP=1: 1/1/0/0.
  - ack=1 -> ISO_REL.
  - Else if req=0 -> PWR_DN.
  - Else if counter==ACK_TIMEOUT-1 -> err set, go OFF.
  - Otherwise counter++.
- ISO_REL=2: 1/0/0/0.
  - Lasts exactly RST_DELAY cycles, then -> ON.
  - req=0 at any point -> ISO_ON.
- ON=3: 1/0/1/1.
  - req=0 -> CLK_OFF.
- CLK_OFF=4: 1/0/1/0.
  - Lasts 1 cycle, then -> ISO_ON.
- ISO_ON=5: 1/1/0/0.
  - Lasts 1 cycle, then -> PWR_DN; counter cleared.
- PWR_DN=6: 0/1/0/0.
  - ack=0 -> OFF.
  - Else if counter==ACK_TIMEOUT-1 -> err set, go OFF.
  - Otherwise counter++.
- 7: illegal; returns to OFF.

Power sequencing rules:
- A req toggle mid-sequence never skips isolation.
- Reset is always asserted before isolation is released.
- Power is only removed while isolated and held in reset.
- Channels are fully independent and may transition in the same cycle.

Interrupts:
- Edge detector: register the previous accel_intr_i.
- Rising edge while state==ON -> pending set at the next edge.
- Edges in any other state are ignored.
- Clear and set in the same cycle: set wins.
- Entering OFF clears pending.
- Mapping:
  - intr_vector_ext_o[i] = pending[i] & mask[i] for i<NCH;
  - bits NCH..NEXT_INT-1 are tied 0.
- Latency: input edge sampled at edge t -> vector line high after edge t+1, i.e. 2 cycles from input change.

Test Plan:
- Power-up, RST_DELAY=4:
  - stimulus: req0=1 at cycle 0; ack0 rises at cycle 5;
  - switch0=1 from cycle 1; iso0=0 from cycle 6; rst_no0=1 and clk_en0=1 from cycle 10; state0=3.
- Ack timeout, ACK_TIMEOUT=8:
  - stimulus: req1=1; ack1 held 0;
  - after 8 cycles in PWR_UP: err1=1, state OFF, switch1=0;
  - while req1 stays 1: no retry;
  - req1 dropped: err1 clears; a new req1=1 restarts PWR_UP.
- Power-down from ON:
  - stimulus: req2=0;
  - clk_en2=0, then iso2=1 with rst_no2=0, then switch2=0 on consecutive cycles;
  - ack2 falls -> OFF; pending2 cleared.
- Interrupt path:
  - stimulus: ch0 ON, mask0=1, accel_intr0 0->1;
  - vector[0]=1 two cycles later; vector[63:NCH]=0;
  - clear pulse coinciding with a second rising edge -> pending0 stays 1;
  - clear alone -> vector[0]=0 next cycle;
  - mask0=0 -> vector[0]=0 while pending0=1.
- Abort mid-sequence:
  - stimulus: req3 dropped during ISO_REL cycle 2;
  - ISO_ON (iso3=1) next cycle, never ON, then PWR_DN -> OFF.
- Async reset mid-ON:
  - stimulus: rst_i pulse with all channels ON;
  - outputs immediately switch=0, iso=1, rst_no=0, clk_en=0; pending=0; err=0.
